// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared FSM encoding, ID width helper and default sizes for matmul_arbiter
package matmul_pkg;

    localparam int DEF_W = 32;
    localparam int DEF_N = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    function automatic int id_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/matmul_arbiter_rr.sv
// rtl/matmul_arbiter_rr.sv - rr_arbiter: R-way round-robin pick starting after the last accepted grant
module rr_arbiter
    import matmul_pkg::*;
#(
    parameter  int R  = 2,
    localparam int IW = id_w(R)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [R-1:0]  i_req,
    input  logic          i_accept,
    output logic [R-1:0]  o_grant,
    output logic [IW-1:0] o_grant_id
);

    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester after last_q is written last and wins.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        idx        = '0;
        for (int i = R; i >= 1; i--) begin
            idx = IW'((int'(last_q) + i) % R);
            if (i_req[idx]) begin
                o_grant      = '0;
                o_grant[idx] = 1'b1;
                o_grant_id   = idx;
            end
        end
        last_d = i_accept ? o_grant_id : last_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= IW'(R - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/matmul_arbiter.sv
// rtl/matmul_arbiter.sv - round-robin job scheduler for one shared systolic matmul engine
// Optional watchdog on the RUN phase is built when MATMUL_ARB_TIMEOUT_EN is defined.
module matmul_arbiter
    import matmul_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int N       = DEF_N,
    parameter int R       = 2,
    parameter int DRAIN   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [R-1:0]           i_req_valid,
    output logic [R-1:0]           o_req_ready,
    input  logic [R-1:0]           i_req_mode,
    input  logic [R*W*N*N-1:0]     i_req_A,
    input  logic [R*W*N*N-1:0]     i_req_B,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [$clog2(R)-1:0]   o_rsp_id,
    output logic [W*N*N-1:0]       o_rsp_C,
    output logic                   o_rsp_err,
    output logic                   o_eng_clr,
    output logic                   o_eng_en,
    output logic                   o_eng_mode,
    output logic [W*N*N-1:0]       o_eng_A,
    output logic [W*N*N-1:0]       o_eng_B,
    input  logic [W*N*N-1:0]       i_eng_C,
    input  logic                   i_eng_done
);

    localparam int MW  = W * N * N;
    localparam int IW  = $clog2(R);
    localparam int DCW = $clog2(DRAIN + 2);

    state_e            state_q, state_d;
    logic [MW-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
    logic              mode_q, mode_d;
    logic [IW-1:0]     id_q, id_d;
    logic              clr_q, clr_d, en_q, en_d;
    logic              rsp_valid_q, rsp_valid_d, err_q, err_d;
    logic [DCW-1:0]    drain_cnt_q, drain_cnt_d;

    logic [R-1:0]      grant;
    logic [IW-1:0]     grant_id;
    logic              accept;

`ifdef MATMUL_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0]    run_cnt_q, run_cnt_d;
`else
    logic              unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    rr_arbiter #(.R(R)) u_rr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req_valid),
        .i_accept   (accept),
        .o_grant    (grant),
        .o_grant_id (grant_id)
    );

    // Ready is combinational so a requester can be taken on the very first IDLE cycle.
    assign o_req_ready = (state_q == ST_IDLE && !i_rst) ? grant : '0;
    assign accept      = |(i_req_valid & o_req_ready);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        mode_d      = mode_q;
        id_d        = id_q;
        clr_d       = 1'b0;
        en_d        = 1'b0;
        rsp_valid_d = rsp_valid_q;
        err_d       = err_q;
        drain_cnt_d = drain_cnt_q;
`ifdef MATMUL_ARB_TIMEOUT_EN
        run_cnt_d   = run_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = i_req_A[grant_id*MW +: MW];
                    b_d     = i_req_B[grant_id*MW +: MW];
                    mode_d  = i_req_mode[grant_id];
                    id_d    = grant_id;
                    err_d   = 1'b0;
                    clr_d   = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                en_d    = 1'b1;
                state_d = ST_RUN;
`ifdef MATMUL_ARB_TIMEOUT_EN
                run_cnt_d = '0;
`endif
            end
            ST_RUN: begin
                en_d = 1'b1;
                if (i_eng_done) begin
                    if (DRAIN == 0) begin
                        c_d         = i_eng_C;
                        en_d        = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end
                end
`ifdef MATMUL_ARB_TIMEOUT_EN
                else if (run_cnt_q == TCW'(TIMEOUT - 1)) begin
                    c_d         = '0;
                    err_d       = 1'b1;
                    en_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                en_d = 1'b1;
                if (drain_cnt_q == DCW'(DRAIN - 1)) begin
                    c_d         = i_eng_C;
                    en_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            mode_q      <= 1'b0;
            id_q        <= '0;
            clr_q       <= 1'b0;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            drain_cnt_q <= '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
            run_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            mode_q      <= mode_d;
            id_q        <= id_d;
            clr_q       <= clr_d;
            en_q        <= en_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            drain_cnt_q <= drain_cnt_d;
`ifdef MATMUL_ARB_TIMEOUT_EN
            run_cnt_q   <= run_cnt_d;
`endif
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = id_q;
    assign o_rsp_C     = c_q;
    assign o_rsp_err   = err_q;
    assign o_eng_clr   = clr_q;
    assign o_eng_en    = en_q;
    assign o_eng_mode  = mode_q;
    assign o_eng_A     = a_q;
    assign o_eng_B     = b_q;

endmodule

// File: tb/tb_matmul_arbiter.sv
// tb/tb_matmul_arbiter.sv - randomized self-checking bench for matmul_arbiter with a behavioural engine model
module tb_matmul_arbiter;

    localparam int W       = 32;
    localparam int N       = 3;
    localparam int R       = 2;
    localparam int DRAIN   = 2;
    localparam int TIMEOUT = 64;
    localparam int MW      = W * N * N;
    localparam int IW      = $clog2(R);

    logic              clk = 1'b0;
    logic              rst;
    logic [R-1:0]      req_valid, req_ready, req_mode;
    logic [R*MW-1:0]   req_A, req_B;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [IW-1:0]     rsp_id;
    logic [MW-1:0]     rsp_C, eng_A, eng_B, eng_C;
    logic              eng_clr, eng_en, eng_mode, eng_done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int mdl_last     = R - 1;
    logic [MW-1:0] mdl_a [R];
    logic [MW-1:0] mdl_b [R];
    logic          mdl_m [R];

    int run_len = 4;
    bit stall   = 1'b0;
    int eng_cnt = 0;

    matmul_arbiter #(.W(W), .N(N), .R(R), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_mode  (req_mode),
        .i_req_A     (req_A),
        .i_req_B     (req_B),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_C     (rsp_C),
        .o_rsp_err   (rsp_err),
        .o_eng_clr   (eng_clr),
        .o_eng_en    (eng_en),
        .o_eng_mode  (eng_mode),
        .o_eng_A     (eng_A),
        .o_eng_B     (eng_B),
        .i_eng_C     (eng_C),
        .i_eng_done  (eng_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [MW-1:0] mat_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        logic [W-1:0]  s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) s = s + a[(i*N+k)*W +: W] * b[(k*N+j)*W +: W];
                r[(i*N+j)*W +: W] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] r;
        for (int i = 0; i < N*N; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    function automatic int rr_pick(input logic [R-1:0] v, input int last);
        for (int i = 1; i <= R; i++) begin
            if (v[(last + i) % R]) return (last + i) % R;
        end
        return -1;
    endfunction

    function automatic logic [R-1:0] onehot(input int g);
        logic [R-1:0] one;
        one = {{(R-1){1'b0}}, 1'b1};
        return one << g;
    endfunction

    // Engine: counts enabled cycles after a clear and raises done after run_len of them.
    always @(posedge clk) begin
        if (rst || eng_clr) begin
            eng_cnt  <= 0;
            eng_done <= 1'b0;
        end else if (eng_en && !stall && !eng_done) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt + 1 >= run_len) eng_done <= 1'b1;
        end
    end
    assign eng_C = mat_mul(eng_A, eng_B);

    task automatic load_req(input int r, input logic [MW-1:0] a, input logic [MW-1:0] b, input logic m);
        req_A[r*MW +: MW] = a;
        req_B[r*MW +: MW] = b;
        req_mode[r]       = m;
        mdl_a[r] = a;
        mdl_b[r] = b;
        mdl_m[r] = m;
    endtask

    task automatic run_to_rsp(input logic exp_mode, output bit to, output bit rdy_seen,
                              output bit mode_bad, output int en_cycles);
        to = 1'b1; rdy_seen = 1'b0; mode_bad = 1'b0; en_cycles = 0;
        for (int k = 0; k < 500; k++) begin
            if (rsp_valid) begin
                to = 1'b0;
                break;
            end
            if (req_ready != '0) rdy_seen = 1'b1;
            if ((eng_clr || eng_en) && eng_mode !== exp_mode) mode_bad = 1'b1;
            if (eng_en) en_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_mode = '0; req_A = '0; req_B = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({rsp_valid, eng_clr, eng_en, eng_mode, rsp_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000", {rsp_valid, eng_clr, eng_en, eng_mode, rsp_err});
        end
        tests_run++;
        if (eng_A !== '0 || eng_B !== '0 || rsp_C !== '0 || rsp_id !== '0 || req_ready !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: A=%0h B=%0h C=%0h id=%0d rdy=%b expected all 0", eng_A, eng_B, rsp_C, rsp_id, req_ready);
        end
        rst = 1'b0;
        mdl_last = R - 1;
        @(negedge clk);
    endtask

    task automatic test_single_job();
        logic [MW-1:0] a, b;
        int t0, en_cyc, done_cyc, clr_cnt;
        bit to;
        a = '0; b = '0;
        for (int i = 0; i < N*N; i++) begin
            a[i*W +: W] = W'(((i / N) == (i % N)) ? 1 : 0);
            b[i*W +: W] = W'(i + 1);
        end
        load_req(0, a, b, 1'b0);
        run_len = 4; rsp_ready = 1'b1;
        req_valid = 2'b01; #1;
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_ready: got %b expected 01", req_ready);
        end
        t0 = cyc; mdl_last = 0;
        @(negedge clk); req_valid = '0;
        tests_run++;
        if (eng_clr !== 1'b1 || eng_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_clear: clr=%b en=%b expected clr=1 en=0", eng_clr, eng_en);
        end
        clr_cnt = 0; en_cyc = -1; done_cyc = -1; to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (rsp_valid) begin
                to = 1'b0;
                break;
            end
            if (eng_clr) clr_cnt++;
            if (eng_en && en_cyc < 0) en_cyc = cyc;
            if (eng_en && eng_done && done_cyc < 0) done_cyc = cyc;
            @(negedge clk);
        end
        tests_run++;
        if (to || clr_cnt != 1) begin
            tests_failed++;
            $display("FAIL single_clr_pulse: timeout=%0d clr_cycles=%0d expected 0 and 1", to, clr_cnt);
        end
        tests_run++;
        if (en_cyc != t0 + 2) begin
            tests_failed++;
            $display("FAIL single_run_start: got cycle %0d expected %0d", en_cyc, t0 + 2);
        end
        tests_run++;
        if (cyc != done_cyc + DRAIN + 1) begin
            tests_failed++;
            $display("FAIL single_rsp_latency: got cycle %0d expected %0d", cyc, done_cyc + DRAIN + 1);
        end
        tests_run++;
        if (rsp_C !== b || rsp_id !== '0 || rsp_err !== 1'b0 || eng_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_rsp: C=%0h id=%0d err=%b en=%b expected C=%0h id=0 err=0 en=0", rsp_C, rsp_id, rsp_err, eng_en, b);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [MW-1:0] exp_c, snap_c;
        logic [IW-1:0] snap_id;
        bit to, rdy, mb, stable;
        int enc;
        rsp_ready = 1'b0;
        load_req(1, rand_mat(), rand_mat(), 1'b0);
        run_len = $urandom_range(1, 6);
        req_valid = 2'b10; #1;
        tests_run++;
        if (req_ready !== onehot(rr_pick(req_valid, mdl_last))) begin
            tests_failed++;
            $display("FAIL bp_grant: got %b expected %b", req_ready, onehot(rr_pick(req_valid, mdl_last)));
        end
        exp_c = mat_mul(mdl_a[1], mdl_b[1]); mdl_last = 1;
        @(negedge clk);
        load_req(1, rand_mat(), rand_mat(), 1'b0);
        run_to_rsp(1'b0, to, rdy, mb, enc);
        tests_run++;
        if (to || rdy || rsp_C !== exp_c || rsp_id !== IW'(1)) begin
            tests_failed++;
            $display("FAIL bp_rsp: to=%0d rdy=%0d C=%0h id=%0d expected C=%0h id=1", to, rdy, rsp_C, rsp_id, exp_c);
        end
        snap_c = rsp_C; snap_id = rsp_id; stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_C !== snap_c || rsp_id !== snap_id || req_ready !== '0) stable = 1'b0;
        end
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("FAIL bp_hold: valid=%b C=%0h id=%0d rdy=%b expected stable response", rsp_valid, rsp_C, rsp_id, req_ready);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        tests_run++;
        if (req_ready !== 2'b10 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: rdy=%b valid=%b expected rdy=10 valid=0", req_ready, rsp_valid);
        end
        req_valid = '0;
        @(negedge clk);
        req_valid = 2'b01; #1;
        tests_run++;
        if (req_ready !== onehot(rr_pick(req_valid, mdl_last))) begin
            tests_failed++;
            $display("FAIL bp_drop_no_grant: got %b expected %b", req_ready, onehot(rr_pick(req_valid, mdl_last)));
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        bit reached, seen_rsp;
        load_req(0, rand_mat(), rand_mat(), 1'b1);
        run_len = 30;
        req_valid = 2'b01; #1;
        @(negedge clk); req_valid = '0;
        reached = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (eng_en) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!reached) begin
            tests_failed++;
            $display("FAIL midrst_run: engine enable not seen, got 0 expected 1");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        tests_run++;
        if ({rsp_valid, eng_clr, eng_en, eng_mode, rsp_err} !== 5'b0 || eng_A !== '0 || eng_B !== '0 ||
            rsp_C !== '0 || rsp_id !== '0 || req_ready !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: ctrl=%b A=%0h B=%0h C=%0h expected all 0",
                     {rsp_valid, eng_clr, eng_en, eng_mode, rsp_err}, eng_A, eng_B, rsp_C);
        end
        mdl_last = R - 1;
        seen_rsp = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1'b1;
        end
        tests_run++;
        if (seen_rsp) begin
            tests_failed++;
            $display("FAIL midrst_no_rsp: got response expected none");
        end
        req_valid = 2'b11; #1;
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL midrst_priority: got %b expected 01", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] exp_c;
        bit to, rdy, mb;
        int enc, g;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < R; r++) load_req(r, rand_mat(), rand_mat(), 1'b0);
            run_len = $urandom_range(1, 6);
            req_valid = '1; #1;
            g = k % R;
            tests_run++;
            if (req_ready !== onehot(g)) begin
                tests_failed++;
                $display("FAIL rr_order[%0d]: got %b expected %b", k, req_ready, onehot(g));
            end
            exp_c = mat_mul(mdl_a[g], mdl_b[g]);
            mdl_last = g;
            @(negedge clk);
            run_to_rsp(1'b0, to, rdy, mb, enc);
            tests_run++;
            if (to || rdy || rsp_id !== IW'(g) || rsp_C !== exp_c) begin
                tests_failed++;
                $display("FAIL rr_rsp[%0d]: to=%0d rdy_during_job=%0d id=%0d C=%0h expected id=%0d C=%0h",
                         k, to, rdy, rsp_id, rsp_C, g, exp_c);
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_mode();
        logic [MW-1:0] exp_c;
        bit to, rdy, mb;
        int enc;
        load_req(0, rand_mat(), rand_mat(), 1'b0);
        load_req(1, rand_mat(), rand_mat(), 1'b1);
        run_len = $urandom_range(2, 6);
        req_valid = 2'b10; #1;
        tests_run++;
        if (req_ready !== onehot(rr_pick(req_valid, mdl_last))) begin
            tests_failed++;
            $display("FAIL mode_grant: got %b expected %b", req_ready, onehot(rr_pick(req_valid, mdl_last)));
        end
        exp_c = mat_mul(mdl_a[1], mdl_b[1]); mdl_last = 1;
        @(negedge clk); req_valid = '0;
        run_to_rsp(1'b1, to, rdy, mb, enc);
        tests_run++;
        if (to || mb || enc == 0 || rsp_id !== IW'(1) || rsp_C !== exp_c) begin
            tests_failed++;
            $display("FAIL mode_pass: to=%0d mode_bad=%0d en_cycles=%0d id=%0d C=%0h expected mode 1 held, id=1 C=%0h",
                     to, mb, enc, rsp_id, rsp_C, exp_c);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [MW-1:0] exp_c;
        logic [R-1:0]  v;
        logic          em;
        bit to, rdy, mb;
        int enc, g;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            v = R'($urandom_range(1, (1 << R) - 1));
            for (int r = 0; r < R; r++) load_req(r, rand_mat(), rand_mat(), 1'($urandom_range(0, 1)));
            run_len = $urandom_range(1, 8);
            req_valid = v; #1;
            g = rr_pick(v, mdl_last);
            tests_run++;
            if (req_ready !== onehot(g)) begin
                tests_failed++;
                $display("FAIL rand_grant[%0d]: valid=%b got %b expected %b", k, v, req_ready, onehot(g));
            end
            exp_c = mat_mul(mdl_a[g], mdl_b[g]); em = mdl_m[g]; mdl_last = g;
            @(negedge clk);
            req_valid = '0;
            for (int r = 0; r < R; r++) load_req(r, rand_mat(), rand_mat(), 1'($urandom_range(0, 1)));
            run_to_rsp(em, to, rdy, mb, enc);
            tests_run++;
            if (to || rdy || mb || rsp_id !== IW'(g) || rsp_C !== exp_c || rsp_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_rsp[%0d]: to=%0d rdy=%0d mode_bad=%0d id=%0d err=%b C=%0h expected id=%0d C=%0h",
                         k, to, rdy, mb, rsp_id, rsp_err, rsp_C, g, exp_c);
            end
            @(negedge clk);
        end
    endtask

`ifdef MATMUL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit to, rdy, mb;
        int enc;
        stall = 1'b1; rsp_ready = 1'b1;
        load_req(0, rand_mat(), rand_mat(), 1'b0);
        req_valid = 2'b01; #1;
        mdl_last = rr_pick(req_valid, mdl_last);
        @(negedge clk); req_valid = '0;
        run_to_rsp(1'b0, to, rdy, mb, enc);
        tests_run++;
        if (to || enc != TIMEOUT || rsp_err !== 1'b1 || rsp_C !== '0) begin
            tests_failed++;
            $display("FAIL timeout: to=%0d run_cycles=%0d err=%b C=%0h expected %0d cycles err=1 C=0",
                     to, enc, rsp_err, rsp_C, TIMEOUT);
        end
        stall = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL global_watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_job();
        test_backpressure();
        test_reset_mid_job();
        test_back_to_back();
        test_mode();
        test_random();
`ifdef MATMUL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
